// File: rtl/pe_lin_array.sv
// Linear chain of N unsigned MAC lanes with programmable weights. A single
// activation stream is forwarded one lane per cycle; each lane clamps its result to OW bits.
module pe_lin_array #(
  parameter int N  = 4,
  parameter int AW = 8,
  parameter int WW = 8,
  parameter int OW = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_we,
  input  logic [$clog2(N)-1:0] w_sel,
  input  logic [WW-1:0]        w_data,
  input  logic                 mode,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic [AW-1:0]        in_data,
  output logic [N*OW-1:0]      acc_out,
  output logic [N-1:0]         out_valid,
  output logic [N-1:0]         sat
);

  localparam int SW = $clog2(N);
  localparam int PW = AW + WW;
  localparam int XW = ((OW > PW) ? OW : PW) + 1;
  localparam logic [XW-1:0] ACC_MAX = XW'({OW{1'b1}});

  logic [WW-1:0] w      [N];
  logic [AW-1:0] a_fwd  [N-1];
  logic [N-2:0]  v_fwd;
  logic [OW-1:0] acc    [N];
  logic [AW-1:0] lane_a [N];
  logic [N-1:0]  lane_v;
  logic [PW-1:0] prod   [N];
  logic [XW-1:0] sum    [N];
  logic [OW-1:0] nxt    [N];
  logic [N-1:0]  hit;

  always_comb begin
    lane_v[0] = in_valid;
    lane_a[0] = in_data;
    for (int unsigned i = 1; i < N; i++) begin
      lane_v[i] = v_fwd[i-1];
      lane_a[i] = a_fwd[i-1];
    end
  end

  // clr or product mode drops the old contents, so the lane loads the bare product.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      prod[i] = PW'(w[i]) * PW'(lane_a[i]);
      sum[i]  = ((clr || mode) ? '0 : XW'(acc[i])) + XW'(prod[i]);
      hit[i]  = (sum[i] > ACC_MAX);
      nxt[i]  = hit[i] ? '1 : sum[i][OW-1:0];
    end
  end

  always_comb begin
    acc_out = '0;
    for (int unsigned i = 0; i < N; i++) begin
      acc_out[i*OW +: OW] = acc[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_fwd     <= '0;
      out_valid <= '0;
      sat       <= '0;
      for (int unsigned i = 0; i < N - 1; i++) begin
        a_fwd[i] <= '0;
      end
      for (int unsigned i = 0; i < N; i++) begin
        w[i]   <= '0;
        acc[i] <= '0;
      end
    end else begin
      a_fwd[0] <= in_data;
      v_fwd[0] <= in_valid;
      for (int unsigned i = 1; i < N - 1; i++) begin
        a_fwd[i] <= a_fwd[i-1];
        v_fwd[i] <= v_fwd[i-1];
      end
      out_valid <= lane_v;
      for (int unsigned i = 0; i < N; i++) begin
        // Indices >= N never match, so out-of-range writes are dropped.
        if (w_we && w_sel == SW'(i)) begin
          w[i] <= w_data;
        end
        if (lane_v[i]) begin
          acc[i] <= nxt[i];
          sat[i] <= (sat[i] & ~clr) | hit[i];
        end else if (clr) begin
          acc[i] <= '0;
          sat[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_lin_array.sv
// Directed bench for pe_lin_array (N=4, AW=8, WW=8, OW=12) with hand-computed expectations.
module tb_pe_lin_array;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int WW = 8;
  localparam int OW = 12;

  logic          clk = 1'b0;
  logic          rst, w_we, mode, clr, in_valid;
  logic [1:0]    w_sel;
  logic [WW-1:0] w_data;
  logic [AW-1:0] in_data;
  logic [N*OW-1:0] acc_out;
  logic [N-1:0]  out_valid, sat;

  int n_vec = 0;
  int n_bad = 0;

  pe_lin_array #(.N(N), .AW(AW), .WW(WW), .OW(OW)) dut (
    .clk(clk), .rst(rst), .w_we(w_we), .w_sel(w_sel), .w_data(w_data),
    .mode(mode), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .acc_out(acc_out), .out_valid(out_valid), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] lane(input int i);
    return acc_out[i*OW +: OW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int sel, input int data);
    w_we = 1'b1; w_sel = 2'(sel); w_data = WW'(data);
    tick();
    w_we = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; w_we = 1'b0; w_sel = '0; w_data = '0; mode = 1'b0; clr = 1'b0;
    in_valid = 1'b0; in_data = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_acc", acc_out[31:0], 0);
    check("rst_acc_hi", 32'(acc_out[N*OW-1:32]), 0);
    check("rst_ov", 32'(out_valid), 0);
    check("rst_sat", 32'(sat), 0);

    // Basic stream: w=1..4, a=1..8 on edges 0..7.
    for (int i = 0; i < N; i++) wr(i, i + 1);
    mode = 1'b0;
    for (int e = 0; e < 12; e++) begin
      logic [N-1:0] exp_ov;
      in_valid = (e < 8);
      in_data  = AW'(e + 1);
      tick();
      for (int i = 0; i < N; i++) begin
        int m;
        m = e - i + 1;
        if (m < 0) m = 0;
        if (m > 8) m = 8;
        exp_ov[i] = (e >= i) && (e <= i + 7);
        check($sformatf("basic_e%0d_l%0d", e, i), 32'(lane(i)), (i + 1) * m * (m + 1) / 2);
      end
      check($sformatf("basic_ov_e%0d", e), 32'(out_valid), 32'(exp_ov));
    end
    in_valid = 1'b0;

    // Saturation on lane 0, then clear.
    pulse_clr();
    wr(0, 255);
    in_valid = 1'b1; in_data = 8'd255;
    tick();
    in_valid = 1'b0;
    check("sat_acc0", 32'(lane(0)), 4095);
    check("sat_flag0", 32'(sat[0]), 1);
    tick(); tick(); tick();
    check("sat_sticky", 32'(sat), 32'b0001);
    check("sat_l3", 32'(lane(3)), 1020);
    pulse_clr();
    check("clr_acc0", 32'(lane(0)), 0);
    check("clr_sat", 32'(sat), 0);
    check("clr_all", acc_out[31:0], 0);

    // Product mode: a=5 then 7, no accumulation.
    wr(0, 1);
    mode = 1'b1;
    in_valid = 1'b1; in_data = 8'd5; tick();
    in_data = 8'd7; tick();
    check("prod_l0", 32'(lane(0)), 7);
    in_valid = 1'b0;
    tick();
    check("prod_l1", 32'(lane(1)), 14);
    tick();
    check("prod_l3_e3", 32'(lane(3)), 20);
    tick();
    check("prod_l3_e4", 32'(lane(3)), 28);
    mode = 1'b0;

    // clr mid-stream at edge 3 of a six-edge stream of ones.
    for (int i = 0; i < N; i++) wr(i, 1);
    pulse_clr();
    for (int e = 0; e < 6; e++) begin
      in_valid = 1'b1; in_data = 8'd1; clr = (e == 3);
      tick();
    end
    in_valid = 1'b0; clr = 1'b0;
    for (int i = 0; i < N; i++) check($sformatf("midclr_e5_l%0d", i), 32'(lane(i)), 3);
    tick(); tick(); tick();
    for (int i = 0; i < N; i++) check($sformatf("midclr_end_l%0d", i), 32'(lane(i)), 3 + i);

    // Weight write in flight at edge 2, together with clr.
    pulse_clr();
    in_valid = 1'b1; in_data = 8'd2; tick();
    in_valid = 1'b0; tick();
    w_we = 1'b1; w_sel = 2'd3; w_data = 8'd5; clr = 1'b1; tick();
    w_we = 1'b0; clr = 1'b0; tick();
    check("wfly_l0", 32'(lane(0)), 0);
    check("wfly_l1", 32'(lane(1)), 0);
    check("wfly_l2", 32'(lane(2)), 2);
    check("wfly_l3", 32'(lane(3)), 10);

    // Variant: the write lands on lane 3's update edge, so the old weight is used.
    wr(3, 1);
    pulse_clr();
    in_valid = 1'b1; in_data = 8'd2; tick();
    in_valid = 1'b0; tick(); tick();
    w_we = 1'b1; w_sel = 2'd3; w_data = 8'd5; tick();
    w_we = 1'b0;
    check("wlate_l3", 32'(lane(3)), 2);

    // Reset at edge 4 of an 8-activation stream.
    for (int e = 0; e < 12; e++) begin
      logic [N-1:0] exp_ov;
      in_valid = (e < 8);
      in_data  = AW'(e + 1);
      rst      = (e == 4);
      tick();
      for (int i = 0; i < N; i++) begin
        if (e < 4) exp_ov[i] = (e >= i);
        else exp_ov[i] = (e - i >= 5) && (e - i <= 7);
      end
      check($sformatf("rstmid_ov_e%0d", e), 32'(out_valid), 32'(exp_ov));
      if (e >= 4) begin
        check($sformatf("rstmid_acc_e%0d", e), acc_out[31:0], 0);
        check($sformatf("rstmid_acchi_e%0d", e), 32'(acc_out[N*OW-1:32]), 0);
      end
      if (e == 4) check("rstmid_sat", 32'(sat), 0);
    end
    rst = 1'b0;
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_lin_array.md
# pe_lin_array

Parametrised linear processing-element chain: N unsigned multiply-accumulate lanes with programmable per-lane weights. A single activation stream enters lane 0 and is forwarded one lane per cycle, so lane i sees every activation i cycles after lane 0. It is the generalised successor of the fixed 4-lane linear PE, adding:
- runtime weight writes
- accumulate/product modes
- synchronous clear
- per-lane output valid
- saturation with sticky flags

## Interface
Parameters:
- N, 4, number of lanes (≥2)
- AW, 8, activation width
- WW, 8, weight width
- OW, 12, accumulator/output width (OW ≤ AW+WW+8)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- w_we  in  1  weight write strobe
- w_sel  in  $clog2(N)  lane index for weight write
- w_data  in  WW  weight value
- mode  in  1  0 = accumulate, 1 = product-only
- clr  in  1  synchronous accumulator/flag clear
- in_valid  in  1  activation valid (fire)
- in_data  in  AW  activation value
- acc_out  out  N*OW  lane i result at bits [i*OW +: OW]
- out_valid  out  N  bit i high for one cycle after lane i updates
- sat  out  N  sticky saturation flag per lane

## Operation
- Forwarding pipe: registers a_fwd[0..N-2] and v_fwd[0..N-2].
  - a_fwd[0] <= in_data, v_fwd[0] <= in_valid.
  - a_fwd[i] <= a_fwd[i-1], v_fwd[i] <= v_fwd[i-1].
- Lane inputs: lane 0 operates on (in_valid, in_data); lane i>0 operates on (v_fwd[i-1], a_fwd[i-1]).
- Product: p = w_i * a, unsigned, full width AW+WW.
- Accumulate mode: acc_i <= min(acc_i + p, 2^OW-1).
- Product mode: acc_i <= min(p, 2^OW-1).
- Saturation: sat[i] is set when the clamp engages and stays set until clr or rst.
- No valid at a lane: acc_i holds.
- Weight write: at an edge with w_we, w[w_sel] <= w_data.
  - A lane update at that same edge uses the old weight.
  - w_sel ≥ N: the write is ignored.
- clr:
  - Sets acc_i to 0 and sat to 0 for all lanes.
  - Exception: a lane with valid at that same edge loads min(p, 2^OW-1) instead of accumulating onto old contents, and sat[i] reflects only that load.
  - Forwarding pipe and weights are unaffected; in-flight activations continue.
- mode is sampled per lane at its update edge and may change mid-stream.
- out_valid[i] <= lane-i valid, i.e. a registered copy, cleared by rst only.
- rst has priority over everything. It zeroes:
  - weights, accumulators, forwarding pipe, out_valid, sat
  - in-flight activations, which are discarded

## Timing
- Reset values: acc_out = 0, out_valid = 0, sat = 0; internal weights = 0.
- For an activation accepted at edge t, lane i updates at edge t+i; the result is visible on acc_out and out_valid[i] in the cycle after edge t+i.
- Throughput: one activation per cycle, no backpressure, in_valid may be high continuously.
- Full-stream latency: the last activation at edge t reaches lane N-1 at edge t+N-1.
- rst asserted mid-stream: everything is zero after that edge, and no out_valid follows for activations accepted before it.
- Simultaneous w_we and clr: both take effect independently at the same edge.

## Test plan
- Basic stream:
  - Stimulus: rst, write w = 1,2,3,4, mode=0, then a = 1..8 on consecutive edges 0..7, then in_valid=0.
  - Required: lane i reads 36·(i+1), i.e. 36, 72, 108, 144, after edge 7+i.
  - Required: out_valid[i] high exactly 8 cycles starting after edge i; values then hold.
- Saturation:
  - Stimulus: w0 = 255, a = 255 once.
  - Required: acc0 = 4095, sat[0] = 1.
  - Required: a following clr gives acc0 = 0, sat[0] = 0.
- Product mode:
  - Stimulus: w = 1,2,3,4, mode=1, a = 5 then 7.
  - Required: lane 3 shows 20 after edge 3, then 28 after edge 4, with no accumulation.
- clr mid-stream:
  - Stimulus: w = 1,1,1,1, a = 1 every edge 0..5, clr at edge 3.
  - Required: after edge 5, acc0 = 3 and acc3 = 3; acc3 is unaffected by pre-clr data because lane 3 first updates at edge 3, which loads 1.
- Weight change in flight:
  - Stimulus: w = 1,1,1,1, a = 2 at edge 0, w_we w_sel=3 w_data=5 at edge 2.
  - Required: acc3 = 10 after edge 3.
  - Variant: if the write is at edge 3 instead, acc3 = 2.
- Reset mid-stream:
  - Stimulus: stream a = 1..8 with rst at edge 4.
  - Required: all outputs are 0 after edge 4, and no out_valid occurs for data issued before edge 4.
